// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: decode/execute/mem/wb register info in,
// forwarding selects, stall/flush controls and mul/div status out.
interface hazard_ctrl_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 32
);
    logic [AW-1:0]    rs1_d;
    logic [AW-1:0]    rs2_d;
    logic             use_rs1_d;
    logic             use_rs2_d;
    logic [AW-1:0]    rs1_e;
    logic [AW-1:0]    rs2_e;
    logic [AW-1:0]    rd_e;
    logic             wen_e;
    logic             load_e;
    logic             md_e;
    logic             redirect_e;
    logic [AW-1:0]    rd_m;
    logic             wen_m;
    logic [AW-1:0]    rd_w;
    logic             wen_w;
    logic [1:0]       r1_sel;
    logic [1:0]       r2_sel;
    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             flush_d;
    logic             flush_e;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: supplies register info, consumes controls
    modport master (
        output rs1_d, rs2_d, use_rs1_d, use_rs2_d, rs1_e, rs2_e, rd_e, wen_e,
               load_e, md_e, redirect_e, rd_m, wen_m, rd_w, wen_w,
        input  r1_sel, r2_sel, stall_f, stall_d, stall_e, flush_d, flush_e,
               md_busy, md_done, stall_cnt
    );

    // Hazard controller side
    modport slave (
        input  rs1_d, rs2_d, use_rs1_d, use_rs2_d, rs1_e, rs2_e, rd_e, wen_e,
               load_e, md_e, redirect_e, rd_m, wen_m, rd_w, wen_w,
        output r1_sel, r2_sel, stall_f, stall_d, stall_e, flush_d, flush_e,
               md_busy, md_done, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage rv32 core: EX operand
// forwarding, load-use stall, multi-cycle mul/div stall FSM, redirect
// flush and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int AW     = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam int CW = $clog2(MD_LAT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    md_state_e        state_q;
    logic [CW-1:0]    cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             md_busy_c;
    logic             md_done_c;
    logic             lu_c;

    // MEM result beats WB result; x0 always reads the register file
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] rs,
        input logic [AW-1:0] rd_m,
        input logic          wen_m,
        input logic [AW-1:0] rd_w,
        input logic          wen_w
    );
        if (rs != '0 && wen_m && rd_m == rs)
            return 2'd1;
        else if (rs != '0 && wen_w && rd_w == rs)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    // Operand forwarding selects, independent of reset
    always_comb begin
        bus.r1_sel = fwd_sel(bus.rs1_e, bus.rd_m, bus.wen_m, bus.rd_w, bus.wen_w);
        bus.r2_sel = fwd_sel(bus.rs2_e, bus.rd_m, bus.wen_m, bus.rd_w, bus.wen_w);
    end

    // Hazard detection and prioritised stall/flush generation
    always_comb begin
        lu_c      = bus.load_e && bus.wen_e && (bus.rd_e != '0) &&
                    ((bus.use_rs1_d && bus.rs1_d == bus.rd_e) ||
                     (bus.use_rs2_d && bus.rs2_d == bus.rd_e));
        md_busy_c = !rst && (((state_q == S_IDLE) && bus.md_e) ||
                             ((state_q == S_BUSY) && (cnt_q != '0)));
        md_done_c = !rst && (state_q == S_BUSY) && (cnt_q == '0);

        bus.stall_f = 1'b0;
        bus.stall_d = 1'b0;
        bus.stall_e = 1'b0;
        bus.flush_d = 1'b0;
        bus.flush_e = 1'b0;
        if (rst) begin
            // everything held low while in reset
        end else if (md_busy_c) begin
            bus.stall_f = 1'b1;
            bus.stall_d = 1'b1;
            bus.stall_e = 1'b1;
        end else if (bus.redirect_e) begin
            // decode instruction is wrong-path, so a pending load-use is moot
            bus.flush_d = 1'b1;
            bus.flush_e = 1'b1;
        end else if (lu_c) begin
            bus.stall_f = 1'b1;
            bus.stall_d = 1'b1;
            bus.flush_e = 1'b1;
        end

        bus.md_busy   = !rst && (state_q == S_BUSY);
        bus.md_done   = md_done_c;
        bus.stall_cnt = stall_cnt_q;
    end

    // Mul/div occupancy FSM; md_e is ignored in the done cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.md_e) begin
                        state_q <= S_BUSY;
                        cnt_q   <= CW'(MD_LAT - 1);
                    end
                end
                S_BUSY: begin
                    if (cnt_q != '0)
                        cnt_q <= cnt_q - CW'(1);
                    else
                        state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Saturating count of decode-stall cycles
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (bus.stall_d && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus
// randomized traffic against a cycle-timeline reference model.
module tb_hazard_ctrl;
    localparam int AW     = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 32;
    localparam int CNT_W3 = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.AW(AW), .CNT_W(CNT_W))  hif ();
    hazard_ctrl_if #(.AW(AW), .CNT_W(CNT_W3)) hif3 ();

    hazard_ctrl #(.AW(AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    hazard_ctrl #(.AW(AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (hif3.slave)
    );

    // md_e and redirect_e together is an illegal encoding
    always @(negedge clk) begin
        if (!rst)
            assert (!(hif.md_e && hif.redirect_e))
                else $error("illegal md_e with redirect_e");
    end

    // ---------------- reference model ----------------
    // Mul/div tracked as the cycle number it started; age 0..MD_LAT-1
    // stalls, age MD_LAT is the done cycle, anything else is idle.
    int     cyc   = 0;
    int     md_t0 = -1;
    longint scnt  = 0;
    localparam longint SMAX = (64'd1 << CNT_W) - 1;

    // packed order: stall_f stall_d stall_e flush_d flush_e md_busy md_done
    function automatic logic [6:0] ctl();
        return {hif.stall_f, hif.stall_d, hif.stall_e, hif.flush_d,
                hif.flush_e, hif.md_busy, hif.md_done};
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
        if (rs == 0) return 2'd0;
        if (hif.wen_m && hif.rd_m == rs) return 2'd1;
        if (hif.wen_w && hif.rd_w == rs) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit model_idle();
        return (md_t0 < 0) || (cyc - md_t0 > MD_LAT);
    endfunction

    function automatic logic [6:0] model_ctl();
        int age;
        bit md_stall, lu;
        logic sf, sd, se, fd, fe, busy, done;
        age = (md_t0 < 0) ? -1 : cyc - md_t0;
        {sf, sd, se, fd, fe, busy, done} = 7'b0;
        if (!rst) begin
            md_stall = (age >= 0 && age < MD_LAT) || (model_idle() && hif.md_e);
            lu = hif.load_e && hif.wen_e && hif.rd_e != 0 &&
                 ((hif.use_rs1_d && hif.rs1_d == hif.rd_e) ||
                  (hif.use_rs2_d && hif.rs2_d == hif.rd_e));
            busy = (age >= 1 && age <= MD_LAT);
            done = (age == MD_LAT);
            if (md_stall) begin
                sf = 1; sd = 1; se = 1;
            end else if (hif.redirect_e) begin
                fd = 1; fe = 1;
            end else if (lu) begin
                sf = 1; sd = 1; fe = 1;
            end
        end
        return {sf, sd, se, fd, fe, busy, done};
    endfunction

    task automatic model_step(input logic [6:0] e);
        if (rst) begin
            md_t0 = -1;
            scnt  = 0;
        end else begin
            if (model_idle() && hif.md_e) md_t0 = cyc;
            if (e[5] && scnt < SMAX) scnt++;
        end
        cyc++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_in();
        hif.rs1_d = '0; hif.rs2_d = '0; hif.use_rs1_d = 0; hif.use_rs2_d = 0;
        hif.rs1_e = '0; hif.rs2_e = '0; hif.rd_e = '0; hif.wen_e = 0;
        hif.load_e = 0; hif.md_e = 0; hif.redirect_e = 0;
        hif.rd_m = '0; hif.wen_m = 0; hif.rd_w = '0; hif.wen_w = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_in();
        next_cycle();
        rst = 0;
    endtask

    task automatic set_load_use();
        hif.load_e = 1; hif.wen_e = 1; hif.rd_e = 5'd7;
        hif.rs2_d = 5'd7; hif.use_rs2_d = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1;
        clear_in();
        hif.md_e = 1;
        set_load_use();
        hif.rs1_e = 5'd5; hif.rd_m = 5'd5; hif.wen_m = 1;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b want=0000000", ctl());
        end
        checks++;
        if (hif.r1_sel !== 2'd1) begin
            failures++;
            $display("FAIL reset_sel got=%0d want=1", hif.r1_sel);
        end
        next_cycle();
        rst = 0;
        clear_in();
        @(negedge clk);
        checks++;
        if (hif.stall_cnt !== '0 || ctl() !== 7'b0) begin
            failures++;
            $display("FAIL reset_state cnt=%0d ctl=%b want cnt=0 ctl=0000000",
                     hif.stall_cnt, ctl());
        end
        next_cycle();
    endtask

    task automatic test_forwarding();
        logic [AW-1:0] rs, rdm, rdw;
        logic          wm, ww;
        logic [1:0]    want;
        logic [19:0]   tbl [5];
        tbl[0] = {5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 2'd1, 1'b0};
        tbl[1] = {5'd5, 5'd5, 1'b0, 5'd5, 1'b1, 2'd2, 1'b0};
        tbl[2] = {5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'd0, 1'b0};
        tbl[3] = {5'd9, 5'd3, 1'b1, 5'd7, 1'b1, 2'd0, 1'b0};
        tbl[4] = {5'd31, 5'd30, 1'b1, 5'd31, 1'b1, 2'd2, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            {rs, rdm, wm, rdw, ww, want} = tbl[i][19:1];
            hif.rs1_e = rs; hif.rs2_e = rs;
            hif.rd_m = rdm; hif.wen_m = wm; hif.rd_w = rdw; hif.wen_w = ww;
            @(negedge clk);
            checks++;
            if (hif.r1_sel !== want || hif.r2_sel !== want) begin
                failures++;
                $display("FAIL fwd_case%0d r1=%0d r2=%0d want=%0d",
                         i, hif.r1_sel, hif.r2_sel, want);
            end
            next_cycle();
        end
        clear_in();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b1100100) begin
            failures++;
            $display("FAIL lu_stall got=%b want=1100100", ctl());
        end
        next_cycle();
        clear_in();
        hif.rs2_d = 5'd7; hif.use_rs2_d = 1;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0 || hif.stall_cnt !== 32'd1) begin
            failures++;
            $display("FAIL lu_one_cycle ctl=%b cnt=%0d want ctl=0000000 cnt=1",
                     ctl(), hif.stall_cnt);
        end
        next_cycle();
        set_load_use();
        hif.use_rs2_d = 0;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0) begin
            failures++;
            $display("FAIL lu_unused got=%b want=0000000", ctl());
        end
        next_cycle();
        clear_in();
    endtask

    task automatic test_muldiv();
        logic [6:0]  want;
        logic [31:0] wcnt;
        do_reset();
        hif.md_e = 1;
        for (int k = 0; k <= MD_LAT + 1; k++) begin
            @(negedge clk);
            want = {(k < MD_LAT), (k < MD_LAT), (k < MD_LAT), 1'b0, 1'b0,
                    (k >= 1 && k <= MD_LAT), (k == MD_LAT)};
            wcnt = (k < MD_LAT) ? 32'(k) : 32'(MD_LAT);
            checks++;
            if (ctl() !== want || hif.stall_cnt !== wcnt) begin
                failures++;
                $display("FAIL md_cycle%0d ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                         k, ctl(), hif.stall_cnt, want, wcnt);
            end
            next_cycle();
            hif.md_e = 0;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        set_load_use();
        hif.redirect_e = 1;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0001100) begin
            failures++;
            $display("FAIL redir_over_lu got=%b want=0001100", ctl());
        end
        next_cycle();
        clear_in();
        hif.md_e = 1;
        next_cycle();
        hif.md_e = 0;
        hif.redirect_e = 1;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b1110010) begin
            failures++;
            $display("FAIL redir_in_busy got=%b want=1110010", ctl());
        end
        next_cycle();
        clear_in();
        for (int k = 0; k < MD_LAT; k++) next_cycle();
    endtask

    task automatic test_reset_busy();
        do_reset();
        hif.md_e = 1;
        next_cycle();
        hif.md_e = 0;
        next_cycle();
        rst = 1;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0) begin
            failures++;
            $display("FAIL rstbusy_during got=%b want=0000000", ctl());
        end
        next_cycle();
        rst = 0;
        for (int k = 0; k < MD_LAT + 1; k++) begin
            @(negedge clk);
            checks++;
            if (ctl() !== 7'b0 || hif.stall_cnt !== 32'd0) begin
                failures++;
                $display("FAIL rstbusy_after%0d ctl=%b cnt=%0d want ctl=0000000 cnt=0",
                         k, ctl(), hif.stall_cnt);
            end
            next_cycle();
        end
    endtask

    task automatic test_saturation();
        int          nst;
        logic        wst;
        logic [2:0]  wcnt;
        do_reset();
        nst = 0;
        hif3.md_e = 1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            wst  = (j % (MD_LAT + 1)) != MD_LAT;
            wcnt = (nst < 7) ? 3'(nst) : 3'd7;
            checks++;
            if (hif3.stall_d !== wst || hif3.stall_cnt !== wcnt) begin
                failures++;
                $display("FAIL sat_cycle%0d stall_d=%b cnt=%0d want stall_d=%b cnt=%0d",
                         j, hif3.stall_d, hif3.stall_cnt, wst, wcnt);
            end
            if (wst) nst++;
            next_cycle();
        end
        hif3.md_e = 0;
        @(negedge clk);
        checks++;
        if (hif3.stall_cnt !== 3'd7) begin
            failures++;
            $display("FAIL sat_final got=%0d want=7", hif3.stall_cnt);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [6:0] e;
        logic [1:0] w1, w2;
        do_reset();
        md_t0 = -1;
        scnt  = 0;
        for (int i = 0; i < 600; i++) begin
            rst            = ($urandom_range(0, 59) == 0);
            hif.rs1_d      = 5'($urandom_range(0, 3));
            hif.rs2_d      = 5'($urandom_range(0, 3));
            hif.use_rs1_d  = 1'($urandom);
            hif.use_rs2_d  = 1'($urandom);
            hif.rs1_e      = 5'($urandom_range(0, 3));
            hif.rs2_e      = 5'($urandom_range(0, 3));
            hif.rd_e       = 5'($urandom_range(0, 3));
            hif.wen_e      = 1'($urandom);
            hif.load_e     = ($urandom_range(0, 2) == 0);
            hif.md_e       = ($urandom_range(0, 5) == 0);
            hif.redirect_e = hif.md_e ? 1'b0 : ($urandom_range(0, 5) == 0);
            hif.rd_m       = 5'($urandom_range(0, 3));
            hif.wen_m      = 1'($urandom);
            hif.rd_w       = 5'($urandom_range(0, 3));
            hif.wen_w      = 1'($urandom);
            @(negedge clk);
            e  = model_ctl();
            w1 = ref_fwd(hif.rs1_e);
            w2 = ref_fwd(hif.rs2_e);
            checks++;
            if (ctl() !== e || hif.r1_sel !== w1 || hif.r2_sel !== w2 ||
                hif.stall_cnt !== CNT_W'(scnt)) begin
                failures++;
                $display("FAIL rand_cycle%0d ctl=%b r1=%0d r2=%0d cnt=%0d want ctl=%b r1=%0d r2=%0d cnt=%0d",
                         i, ctl(), hif.r1_sel, hif.r2_sel, hif.stall_cnt,
                         e, w1, w2, scnt);
            end
            @(posedge clk);
            model_step(e);
            #1;
        end
        rst = 0;
        clear_in();
    endtask

    initial begin
        rst = 1;
        clear_in();
        hif3.rs1_d = '0; hif3.rs2_d = '0; hif3.use_rs1_d = 0; hif3.use_rs2_d = 0;
        hif3.rs1_e = '0; hif3.rs2_e = '0; hif3.rd_e = '0; hif3.wen_e = 0;
        hif3.load_e = 0; hif3.md_e = 0; hif3.redirect_e = 0;
        hif3.rd_m = '0; hif3.wen_m = 0; hif3.rd_w = '0; hif3.wen_w = 0;
        next_cycle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_muldiv();
        test_redirect();
        test_reset_busy();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
